lsu_cmt_buffer: RTL and testbench
=================================

# lsu_cmt_buffer

Completion buffer directly downstream of the LSU/dcache top. It captures every load/store completion the LSU emits (`ls_done`, load data, destination register, ROB index, exception) into an in-order FIFO. It then drains each entry through two back-pressured channels: a PRF write port and a ROB completion port. The LSU completion interface has no ready signal, so this block absorbs completions unconditionally and raises an almost-full stall toward issue.

## Interface
Parameters:
- `XLEN`, 64: data width.
- `PHY_REG_ADDR_WIDTH`, 6: physical register index width.
- `ROB_INDEX_WIDTH`, 4: ROB index width.
- `EXCEPTION_CODE_WIDTH`, 4: ecause width.
- `DEPTH`, 4: entries; power of two, ≥2.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `flush` in 1: pipeline flush.
- `ls_done_i` in 1: LSU completion strobe (push).
- `load_data_valid_i` in 1: completion carries load data.
- `load_data_i` in XLEN: load result.
- `rd_addr_i` in PHY_REG_ADDR_WIDTH: destination register.
- `rob_index_i` in ROB_INDEX_WIDTH: ROB entry.
- `exception_valid_i` in 1: completion faulted.
- `ecause_i` in EXCEPTION_CODE_WIDTH: fault cause.
- `prf_wr_valid_o` out 1: PRF write request.
- `prf_wr_ready_i` in 1: PRF port granted.
- `prf_wr_addr_o` out PHY_REG_ADDR_WIDTH: PRF write address.
- `prf_wr_data_o` out XLEN: PRF write data.
- `rob_cmt_valid_o` out 1: ROB completion request.
- `rob_cmt_ready_i` in 1: ROB accepted.
- `rob_index_o` out ROB_INDEX_WIDTH: completing ROB entry.
- `exception_valid_o` out 1: completion faulted.
- `ecause_o` out EXCEPTION_CODE_WIDTH: fault cause.
- `almost_full_o` out 1: stall LSU issue.
- `overflow_o` out 1: sticky error flag.

## Operation
- Storage: DEPTH entries of {data, rd, rob, exc, ecause, need_wr}, plus head/tail pointers of log2(DEPTH) bits (natural wrap) and a count of log2(DEPTH)+1 bits.
- Push: on `ls_done_i`, the entry is written at tail. `need_wr = load_data_valid_i & ~exception_valid_i & (rd_addr_i != 0)`.
- Full push: if count==DEPTH and no pop occurs in the same cycle, the entry is dropped and `overflow_o` is set. `overflow_o` clears only on `rst`.
- Head drain, when count>0:
  - `prf_wr_valid_o = need_wr & ~wr_done`.
  - `rob_cmt_valid_o` is asserted for every head entry. ROB completion may fire before, with, or after the PRF write.
- `wr_done`: a head-only flag, set on the PRF handshake and cleared on pop.
- Pop: when the ROB handshake is done (this cycle or earlier, tracked by `cmt_done`) and the PRF write is done or not needed (this cycle or earlier). Both flags clear on pop.
- Each channel fires at most once per entry. A valid output stays asserted with stable payload until its handshake completes.
- Simultaneous push and pop with count==DEPTH: the pop frees the slot and the push is accepted. Count is unchanged and there is no overflow.
- Push into an empty buffer: the entry is visible at the outputs the next cycle. There is no same-cycle bypass.
- `flush`: head, tail, count, `wr_done` and `cmt_done` go to 0. `ls_done_i` is ignored in the flush cycle. Handshakes completing in the flush cycle are discarded.
- `almost_full_o = (count >= DEPTH-1)`, from registered count only.

## Timing
- Reset values: all valid outputs 0, `almost_full_o` 0, `overflow_o` 0, data/address outputs 0. Pointers and count 0.
- Latency: push at cycle N → head outputs valid at N+1 (minimum). With both readies high, the entry pops at N+1.
- Throughput: 1 entry/cycle when both readies are held high.
- Outputs are combinational from head registers and flags. There is no combinational path from `ready` to `valid` on the same channel.
- `rst` mid-drain returns every output to its reset value asynchronously. Operation resumes on the first clock edge after deassertion.

## Test plan
- Single load, rd=5, data 0xDEAD_BEEF, rob=3, both readies 1: push at N → at N+1, `prf_wr_valid_o`=1 with addr 5 and data 0xDEAD_BEEF, and `rob_cmt_valid_o`=1 with index 3. Empty at N+2.
- Load with `prf_wr_ready_i`=0 for 3 cycles, ROB ready 1: the ROB handshake fires at N+1 and `rob_cmt_valid_o` then drops. The PRF write is held stable and fires at N+4; pop at N+4. There is no second ROB completion.
- Store (no data), load to rd=0, and faulting load (ecause 5): no PRF write for any of them. ROB completions occur in order, and the third shows `exception_valid_o`=1 with `ecause_o`=5.
- Five back-to-back pushes with ROB ready 0, DEPTH=4: `almost_full_o`=1 after the third push. The fifth push is dropped and sets `overflow_o`. Raising ready then drains the first four in order.
- Full buffer with simultaneous pop and push: count stays 4, `overflow_o` stays 0, and order is preserved.
- Flush with 3 entries pending and a push in the same cycle: next cycle all valid outputs are 0 and count is 0. A push after the flush cycle drains normally.

Source files
------------

// File: rtl/lsu_cmt_buffer.sv
// Purpose : in-order completion buffer between the LSU and the PRF write / ROB completion ports.
// Latency : a push at cycle N shows at the head outputs at N+1; it can pop at N+1 if both readies are high.
// Backpressure: the LSU side has no ready, so completions are always absorbed; almost_full_o stalls issue.
//
// Ports:
//   clk, rst (async active-high), flush
//   ls_done_i + load/rd/rob/exception fields : completion push from the LSU
//   prf_wr_*  : valid/ready PRF write channel (address/data from the head entry)
//   rob_cmt_* : valid/ready ROB completion channel (index/exception from the head entry)
//   almost_full_o : count >= DEPTH-1
//   overflow_o    : sticky flag set when a completion had to be dropped
module lsu_cmt_buffer #(
    parameter int XLEN                 = 64,
    parameter int PHY_REG_ADDR_WIDTH   = 6,
    parameter int ROB_INDEX_WIDTH      = 4,
    parameter int EXCEPTION_CODE_WIDTH = 4,
    parameter int DEPTH                = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            ls_done_i,
    input  logic                            load_data_valid_i,
    input  logic [XLEN-1:0]                 load_data_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0]   rd_addr_i,
    input  logic [ROB_INDEX_WIDTH-1:0]      rob_index_i,
    input  logic                            exception_valid_i,
    input  logic [EXCEPTION_CODE_WIDTH-1:0] ecause_i,
    output logic                            prf_wr_valid_o,
    input  logic                            prf_wr_ready_i,
    output logic [PHY_REG_ADDR_WIDTH-1:0]   prf_wr_addr_o,
    output logic [XLEN-1:0]                 prf_wr_data_o,
    output logic                            rob_cmt_valid_o,
    input  logic                            rob_cmt_ready_i,
    output logic [ROB_INDEX_WIDTH-1:0]      rob_index_o,
    output logic                            exception_valid_o,
    output logic [EXCEPTION_CODE_WIDTH-1:0] ecause_o,
    output logic                            almost_full_o,
    output logic                            overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(DEPTH - 1);

    // entry storage
    logic [XLEN-1:0]                 data_q   [DEPTH];
    logic [PHY_REG_ADDR_WIDTH-1:0]   rd_q     [DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]      rob_q    [DEPTH];
    logic                            exc_q    [DEPTH];
    logic [EXCEPTION_CODE_WIDTH-1:0] ecause_q [DEPTH];
    logic                            need_q   [DEPTH];

    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          wr_done_q;
    logic          cmt_done_q;
    logic          overflow_q;

    logic not_empty;
    logic full;
    logic head_need;
    logic prf_fire;
    logic rob_fire;
    logic wr_ok;
    logic cmt_ok;
    logic pop;
    logic push_req;
    logic push;
    logic drop;
    logic push_need_wr;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == DEPTH_CNT);
    assign head_need = need_q[head_q];

    // Valids depend only on registered state, never on the same channel's ready.
    assign prf_wr_valid_o  = not_empty & head_need & ~wr_done_q;
    assign rob_cmt_valid_o = not_empty & ~cmt_done_q;

    assign prf_fire = prf_wr_valid_o & prf_wr_ready_i;
    assign rob_fire = rob_cmt_valid_o & rob_cmt_ready_i;

    // Head retires once both channels are satisfied, counting handshakes of this cycle.
    assign wr_ok  = ~head_need | wr_done_q | prf_fire;
    assign cmt_ok = cmt_done_q | rob_fire;
    assign pop    = not_empty & wr_ok & cmt_ok & ~flush;

    // A pop in the same cycle frees the slot, so a push into a full buffer is still taken.
    assign push_req = ls_done_i & ~flush;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign push_need_wr = load_data_valid_i & ~exception_valid_i & (rd_addr_i != '0);

    // Payload is forced to zero while empty so stale entries never leak out after flush/reset.
    assign prf_wr_addr_o     = not_empty ? rd_q[head_q]     : '0;
    assign prf_wr_data_o     = not_empty ? data_q[head_q]   : '0;
    assign rob_index_o       = not_empty ? rob_q[head_q]    : '0;
    assign exception_valid_o = not_empty ? exc_q[head_q]    : 1'b0;
    assign ecause_o          = not_empty ? ecause_q[head_q] : '0;

    assign almost_full_o = (count_q >= AF_CNT);
    assign overflow_o    = overflow_q;

    // Entry payload needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q]   <= load_data_i;
            rd_q[tail_q]     <= rd_addr_i;
            rob_q[tail_q]    <= rob_index_i;
            exc_q[tail_q]    <= exception_valid_i;
            ecause_q[tail_q] <= ecause_i;
            need_q[tail_q]   <= push_need_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wr_done_q  <= 1'b0;
            cmt_done_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (flush) begin
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                wr_done_q  <= 1'b0;
                cmt_done_q <= 1'b0;
            end else begin
                if (push) begin
                    tail_q <= tail_q + AW'(1);
                end
                if (pop) begin
                    head_q     <= head_q + AW'(1);
                    wr_done_q  <= 1'b0;
                    cmt_done_q <= 1'b0;
                end else begin
                    if (prf_fire) begin
                        wr_done_q <= 1'b1;
                    end
                    if (rob_fire) begin
                        cmt_done_q <= 1'b1;
                    end
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CW'(1);
                    2'b01:   count_q <= count_q - CW'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsu_cmt_buffer.sv
// Purpose : self-checking bench for lsu_cmt_buffer: directed vector table plus randomized traffic vs a queue model.
// Latency : inputs driven at negedge, outputs sampled 1ns later, model advanced per rising edge.
// Backpressure: both readies driven from the table or randomly; the model tracks per-entry handshakes.
module tb_lsu_cmt_buffer;

    localparam int XLEN  = 64;
    localparam int PW    = 6;
    localparam int RW    = 4;
    localparam int EW    = 4;
    localparam int DEPTH = 4;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            ls_done_i;
    logic            load_data_valid_i;
    logic [XLEN-1:0] load_data_i;
    logic [PW-1:0]   rd_addr_i;
    logic [RW-1:0]   rob_index_i;
    logic            exception_valid_i;
    logic [EW-1:0]   ecause_i;
    logic            prf_wr_valid_o;
    logic            prf_wr_ready_i;
    logic [PW-1:0]   prf_wr_addr_o;
    logic [XLEN-1:0] prf_wr_data_o;
    logic            rob_cmt_valid_o;
    logic            rob_cmt_ready_i;
    logic [RW-1:0]   rob_index_o;
    logic            exception_valid_o;
    logic [EW-1:0]   ecause_o;
    logic            almost_full_o;
    logic            overflow_o;

    lsu_cmt_buffer #(
        .XLEN(XLEN), .PHY_REG_ADDR_WIDTH(PW), .ROB_INDEX_WIDTH(RW),
        .EXCEPTION_CODE_WIDTH(EW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ls_done_i(ls_done_i), .load_data_valid_i(load_data_valid_i),
        .load_data_i(load_data_i), .rd_addr_i(rd_addr_i),
        .rob_index_i(rob_index_i), .exception_valid_i(exception_valid_i),
        .ecause_i(ecause_i),
        .prf_wr_valid_o(prf_wr_valid_o), .prf_wr_ready_i(prf_wr_ready_i),
        .prf_wr_addr_o(prf_wr_addr_o), .prf_wr_data_o(prf_wr_data_o),
        .rob_cmt_valid_o(rob_cmt_valid_o), .rob_cmt_ready_i(rob_cmt_ready_i),
        .rob_index_o(rob_index_o), .exception_valid_o(exception_valid_o),
        .ecause_o(ecause_o), .almost_full_o(almost_full_o), .overflow_o(overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] data;
        logic [PW-1:0]   rd;
        logic [RW-1:0]   rob;
        logic            exc;
        logic [EW-1:0]   ec;
        logic            need;
    } ent_t;

    typedef struct {
        logic            ld;
        logic            ldv;
        logic [XLEN-1:0] data;
        logic [PW-1:0]   rd;
        logic [RW-1:0]   rob;
        logic            exc;
        logic [EW-1:0]   ec;
        logic            prdy;
        logic            rrdy;
        logic            fl;
        logic [3:0]      e;   // expected {prf_valid, rob_valid, almost_full, overflow}
    } vec_t;

    // reference model: FIFO of completions plus per-head handshake bookkeeping
    ent_t q[$];
    bit   m_wr;
    bit   m_cmt;
    bit   m_ovf;

    int n_chk;
    int n_pass;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic ld, input logic ldv, input logic [XLEN-1:0] data,
                                input logic [PW-1:0] rd, input logic [RW-1:0] rob,
                                input logic exc, input logic [EW-1:0] ec,
                                input logic prdy, input logic rrdy, input logic fl,
                                input logic [3:0] e);
        vec_t v;
        v.ld = ld; v.ldv = ldv; v.data = data; v.rd = rd; v.rob = rob;
        v.exc = exc; v.ec = ec; v.prdy = prdy; v.rrdy = rrdy; v.fl = fl; v.e = e;
        return v;
    endfunction

    function automatic vec_t idle(input logic prdy, input logic rrdy, input logic [3:0] e);
        return mk(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, prdy, rrdy, 1'b0, e);
    endfunction

    task automatic drive(input vec_t v);
        ls_done_i         = v.ld;
        load_data_valid_i = v.ldv;
        load_data_i       = v.data;
        rd_addr_i         = v.rd;
        rob_index_i       = v.rob;
        exception_valid_i = v.exc;
        ecause_i          = v.ec;
        prf_wr_ready_i    = v.prdy;
        rob_cmt_ready_i   = v.rrdy;
        flush             = v.fl;
    endtask

    task automatic check_model();
        ent_t h;
        bit   ne;
        ne = (q.size() != 0);
        h  = '{default: 0};
        if (ne) h = q[0];
        chk("prf_wr_valid",   prf_wr_valid_o,    ne && h.need && !m_wr);
        chk("prf_wr_addr",    prf_wr_addr_o,     h.rd);
        chk("prf_wr_data",    prf_wr_data_o,     h.data);
        chk("rob_cmt_valid",  rob_cmt_valid_o,   ne && !m_cmt);
        chk("rob_index",      rob_index_o,       h.rob);
        chk("exception",      exception_valid_o, h.exc);
        chk("ecause",         ecause_o,          h.ec);
        chk("almost_full",    almost_full_o,     q.size() >= DEPTH - 1);
        chk("overflow",       overflow_o,        m_ovf);
    endtask

    // advance the model across one rising edge with the inputs in v
    task automatic model_step(input vec_t v);
        bit ne, pv, rv, pf, rf, pop;
        ne = (q.size() != 0);
        pv = ne && q[0].need && !m_wr;
        rv = ne && !m_cmt;
        pf = pv && v.prdy;
        rf = rv && v.rrdy;
        if (v.fl) begin
            q.delete();
            m_wr  = 0;
            m_cmt = 0;
        end else begin
            pop = ne && (m_cmt || rf) && (!q[0].need || m_wr || pf);
            if (pop) begin
                void'(q.pop_front());
                m_wr  = 0;
                m_cmt = 0;
            end else begin
                m_wr  = m_wr || pf;
                m_cmt = m_cmt || rf;
            end
            if (v.ld) begin
                if (q.size() < DEPTH) begin
                    ent_t e;
                    e.data = v.data; e.rd = v.rd; e.rob = v.rob; e.exc = v.exc; e.ec = v.ec;
                    e.need = v.ldv && !v.exc && (v.rd != 0);
                    q.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input bit directed, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        check_model();
        if (directed) begin
            chk($sformatf("vec%0d prf_valid", idx),   prf_wr_valid_o,  v.e[3]);
            chk($sformatf("vec%0d rob_valid", idx),   rob_cmt_valid_o, v.e[2]);
            chk($sformatf("vec%0d almost_full", idx), almost_full_o,   v.e[1]);
            chk($sformatf("vec%0d overflow", idx),    overflow_o,      v.e[0]);
        end
        model_step(v);
    endtask

    function automatic vec_t rnd_vec(input int ld_pct);
        vec_t v;
        v.ld   = ($urandom_range(99) < ld_pct);
        v.ldv  = $urandom_range(3) != 0;
        v.data = {$urandom, $urandom};
        v.rd   = ($urandom_range(7) == 0) ? '0 : PW'($urandom);
        v.rob  = RW'($urandom);
        v.exc  = ($urandom_range(7) == 0);
        v.ec   = EW'($urandom);
        v.prdy = $urandom_range(3) != 0;
        v.rrdy = $urandom_range(3) != 0;
        v.fl   = ($urandom_range(31) == 0);
        v.e    = '0;
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_wr  = 0;
        m_cmt = 0;
        m_ovf = 0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        model_reset();
        rst = 1'b1;
        drive(idle(1'b0, 1'b0, 4'b0000));

        // single load, both readies high
        vt.push_back(mk(1, 1, 64'hDEAD_BEEF, 6'd5, 4'd3, 0, 0, 1, 1, 0, 4'b0000));
        vt.push_back(idle(1, 1, 4'b1100));
        vt.push_back(idle(1, 1, 4'b0000));
        // load with PRF stalled three cycles
        vt.push_back(mk(1, 1, 64'h1234, 6'd7, 4'd4, 0, 0, 0, 1, 0, 4'b0000));
        vt.push_back(idle(0, 1, 4'b1100));
        vt.push_back(idle(0, 1, 4'b1000));
        vt.push_back(idle(0, 1, 4'b1000));
        vt.push_back(idle(1, 1, 4'b1000));
        vt.push_back(idle(1, 1, 4'b0000));
        // store, load to rd0, faulting load: no PRF writes
        vt.push_back(mk(1, 0, 64'h11, 6'd3, 4'd1, 0, 0, 1, 1, 0, 4'b0000));
        vt.push_back(mk(1, 1, 64'h55, 6'd0, 4'd2, 0, 0, 1, 1, 0, 4'b0100));
        vt.push_back(mk(1, 1, 64'h66, 6'd9, 4'd3, 1, 4'd5, 1, 1, 0, 4'b0100));
        vt.push_back(idle(1, 1, 4'b0100));
        vt.push_back(idle(1, 1, 4'b0000));
        // fill to full, then push and pop together
        vt.push_back(mk(1, 0, 64'h8, 6'd1, 4'd8,  0, 0, 1, 0, 0, 4'b0000));
        vt.push_back(mk(1, 0, 64'h9, 6'd1, 4'd9,  0, 0, 1, 0, 0, 4'b0100));
        vt.push_back(mk(1, 0, 64'hA, 6'd1, 4'd10, 0, 0, 1, 0, 0, 4'b0100));
        vt.push_back(mk(1, 0, 64'hB, 6'd1, 4'd11, 0, 0, 1, 0, 0, 4'b0110));
        vt.push_back(mk(1, 0, 64'hC, 6'd1, 4'd12, 0, 0, 1, 1, 0, 4'b0110));
        vt.push_back(idle(1, 1, 4'b0110));
        vt.push_back(idle(1, 1, 4'b0110));
        vt.push_back(idle(1, 1, 4'b0100));
        vt.push_back(idle(1, 1, 4'b0100));
        vt.push_back(idle(1, 1, 4'b0000));
        // five pushes with ROB stalled: fifth is dropped
        vt.push_back(mk(1, 1, 64'hA0, 6'd10, 4'd0, 0, 0, 1, 0, 0, 4'b0000));
        vt.push_back(mk(1, 1, 64'hA1, 6'd11, 4'd1, 0, 0, 1, 0, 0, 4'b1100));
        vt.push_back(mk(1, 1, 64'hA2, 6'd12, 4'd2, 0, 0, 1, 0, 0, 4'b0100));
        vt.push_back(mk(1, 1, 64'hA3, 6'd13, 4'd3, 0, 0, 1, 0, 0, 4'b0110));
        vt.push_back(mk(1, 1, 64'hA4, 6'd14, 4'd4, 0, 0, 1, 0, 0, 4'b0110));
        vt.push_back(idle(1, 1, 4'b0111));
        vt.push_back(idle(1, 1, 4'b1111));
        vt.push_back(idle(1, 1, 4'b1101));
        vt.push_back(idle(1, 1, 4'b1101));
        vt.push_back(idle(1, 1, 4'b0001));
        // flush with three pending and a push in the same cycle
        vt.push_back(mk(1, 0, 64'h5, 6'd1, 4'd5, 0, 0, 1, 0, 0, 4'b0001));
        vt.push_back(mk(1, 0, 64'h6, 6'd1, 4'd6, 0, 0, 1, 0, 0, 4'b0101));
        vt.push_back(mk(1, 0, 64'h7, 6'd1, 4'd7, 0, 0, 1, 0, 0, 4'b0101));
        vt.push_back(mk(1, 0, 64'h8, 6'd1, 4'd8, 0, 0, 1, 1, 1, 4'b0111));
        vt.push_back(idle(1, 1, 4'b0001));
        vt.push_back(mk(1, 1, 64'hF00D, 6'd20, 4'd9, 0, 0, 1, 1, 0, 4'b0001));
        vt.push_back(idle(1, 1, 4'b1101));
        vt.push_back(idle(1, 1, 4'b0001));

        // reset state
        #12;
        check_model();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], 1'b1, i);

        for (int i = 0; i < 300; i++) run_vec(rnd_vec(50), 1'b0, i);

        // async reset while entries are pending
        run_vec(mk(1, 1, 64'h77, 6'd3, 4'd1, 0, 0, 0, 0, 0, 4'b0000), 1'b0, 0);
        run_vec(mk(1, 1, 64'h78, 6'd4, 4'd2, 0, 0, 0, 0, 0, 4'b0000), 1'b0, 0);
        @(negedge clk);
        drive(idle(1'b0, 1'b0, 4'b0000));
        #1;
        chk("pre-reset rob_valid", rob_cmt_valid_o, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) run_vec(rnd_vec(30), 1'b0, i);
        for (int i = 0; i < 8; i++) run_vec(idle(1, 1, 4'b0000), 1'b0, i);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
